// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer: load-use bubble, taken-branch squash, data-memory freeze.
// Latency: control outputs are combinational from state/cnt and inputs; state updates each clock.
// Backpressure: a memory access freezes every buffer for MEM_LAT-1 cycles; load-use holds PC and IF/ID.
module pipe_hazard_ctrl #(
  parameter int MEM_LAT = 3,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       id_src1_add,
  input  logic [2:0]       id_src2_add,
  input  logic             id_use_src1,
  input  logic             id_use_src2,
  input  logic             ex_mem_read,
  input  logic [2:0]       ex_write_add,
  input  logic             ex_branch_taken,
  input  logic             em_mem_access,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    START    = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  // A single-cycle memory never needs a freeze; the RUN state consumes one frozen
  // cycle itself, so the wait counter starts at MEM_LAT-2.
  localparam logic       FREEZE_EN = (MEM_LAT > 1);
  localparam logic [3:0] WAIT_INIT = (MEM_LAT > 1) ? 4'(MEM_LAT - 2) : 4'd0;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       load_use;
  logic       run_rules;

  assign load_use = ex_mem_read &
                    ((id_use_src1 & (id_src1_add == ex_write_add)) |
                     (id_use_src2 & (id_src2_add == ex_write_add)));

  // Next-state and control outputs; branch beats load-use, freeze beats both.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    run_rules   = 1'b0;
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    id_ex_en    = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    mem_busy    = 1'b0;

    case (state)
      START: begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        state_nxt   = RUN;
      end
      RUN: begin
        if (em_mem_access && FREEZE_EN) begin
          mem_busy  = 1'b1;
          cnt_nxt   = WAIT_INIT;
          state_nxt = MEM_WAIT;
        end else begin
          run_rules = 1'b1;
        end
      end
      MEM_WAIT: begin
        mem_busy = 1'b1;
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          // Release: EX/MEM advances this cycle, so the access is not re-seen.
          run_rules = 1'b1;
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = START;
      end
    endcase

    if (run_rules) begin
      if (ex_branch_taken) begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
      end else begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
      end
    end

    // Hold the whole pipe quiet while reset is asserted.
    if (!rst) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_mem_en   = 1'b0;
      mem_wb_en   = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      mem_busy    = 1'b0;
    end
  end

  // State and wait-counter registers; reset aborts any pending freeze.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= START;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Saturating count of cycles where the PC was held outside the fill cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if ((state != START) && !pc_en && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage 16-bit pipeline. It drives the enable and flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB buffers. It resolves three conditions:
- load-use data hazards, with a one-cycle bubble;
- taken-branch control hazards, by squashing younger instructions;
- multi-cycle data-memory accesses of the instruction held in the EX/MEM buffer, by freezing the whole pipe.
It also keeps a saturating stall-cycle counter for debug.

Parameters:
MEM_LAT, 3, data-memory access latency in cycles (legal 1..15); 1 means no freeze.
CNT_W, 16, width of the stall_cycles counter.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset (0 = reset)
id_src1_add  input  3  source register 1 of the instruction in ID
id_src2_add  input  3  source register 2 of the instruction in ID
id_use_src1  input  1  ID instruction reads src1
id_use_src2  input  1  ID instruction reads src2
ex_mem_read  input  1  the instruction in EX is a load
ex_write_add  input  3  destination register of the instruction in EX
ex_branch_taken  input  1  branch resolved taken in EX this cycle
em_mem_access  input  1  the instruction in the EX/MEM buffer reads or writes memory
pc_en  output  1  PC update enable
if_id_en  output  1  IF/ID buffer load enable
id_ex_en  output  1  ID/EX buffer load enable
ex_mem_en  output  1  EX/MEM buffer load enable
mem_wb_en  output  1  MEM/WB buffer load enable
if_id_flush  output  1  IF/ID loads a NOP instead of its input
id_ex_flush  output  1  ID/EX loads zero control signals (bubble)
mem_busy  output  1  data-memory access in progress
stall_cycles  output  CNT_W  saturating count of cycles with pc_en=0

Behaviour:
- States: START, RUN, MEM_WAIT. There is a 4-bit wait counter cnt.
- Outputs are combinational from the state, cnt and the inputs. State, cnt and stall_cycles are registered.
- Reset (rst=0, asynchronous):
  - state=START, cnt=0, stall_cycles=0.
  - While rst=0, all enables are 0 and both flushes are 0.
  - mem_busy=0.
- START (exactly one cycle after reset release):
  - all enables 1, if_id_flush=1, id_ex_flush=1, so the pipe fills with bubbles.
  - Next state is RUN.
- Definition: load_use = ex_mem_read & ((id_use_src1 & id_src1_add==ex_write_add) | (id_use_src2 & id_src2_add==ex_write_add)).
- RUN, priority order:
  1. If em_mem_access=1 and MEM_LAT>1, freeze:
     - all enables 0, all flushes 0, mem_busy=1;
     - cnt<=MEM_LAT-2, next state MEM_WAIT;
     - the branch and load_use inputs are ignored this cycle and re-evaluated on release.
  2. Else if ex_branch_taken=1:
     - all enables 1, if_id_flush=1, id_ex_flush=1;
     - this overrides load_use, because the dependent instruction is squashed.
  3. Else if load_use=1:
     - pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1, ex_mem_en=1, mem_wb_en=1;
     - exactly one bubble is inserted.
  4. Else: all enables 1, flushes 0.
- MEM_WAIT:
  - If cnt!=0: freeze (as in RUN rule 1), mem_busy=1, cnt<=cnt-1.
  - If cnt==0 (release cycle):
    - mem_busy=1;
    - outputs follow RUN rules 2–4 using the current inputs;
    - next state is RUN.
    - The access is not re-triggered, because ex_mem_en=1 advances the EX/MEM buffer.
- Freeze length: exactly MEM_LAT-1 frozen cycles per access.
  - MEM_LAT=1: mem_busy is never asserted and em_mem_access has no effect.
- Back-to-back accesses: a new access arriving in RUN immediately after release freezes again.
- stall_cycles:
  - increments on every cycle with state!=START and pc_en=0;
  - saturates at all-ones.
- Reset asserted mid-MEM_WAIT: abort immediately to START. No partial count is retained in cnt.

Test Plan:
- Reset release:
  - rst=0 for 3 cycles: every enable is 0 and stall_cycles=0.
  - Next cycle is START: all enables=1, both flushes=1.
  - Following cycle is RUN with flushes=0.
- Load-use:
  - ex_mem_read=1, ex_write_add=3'd5, id_use_src2=1, id_src2_add=3'd5.
  - Expect pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1 for exactly one cycle, and stall_cycles +1.
  - The same stimulus with id_use_src2=0 gives no stall.
- Branch over load-use:
  - ex_branch_taken=1 together with the load-use stimulus above.
  - Expect pc_en=1, if_id_flush=1, id_ex_flush=1, and stall_cycles unchanged.
- Memory freeze, MEM_LAT=3:
  - Pulse em_mem_access=1 in RUN.
  - Expect 2 cycles with all enables 0 and mem_busy=1, then a release cycle with all enables=1 and mem_busy=1, then mem_busy=0.
  - stall_cycles +2.
- Events during freeze:
  - Assert ex_branch_taken=1 throughout a MEM_LAT=3 freeze.
  - No flush while frozen; the release cycle asserts both flushes.
  - Repeat with MEM_LAT=1: no freeze at all.
- Reset and saturation:
  - Assert rst=0 while cnt=1 in MEM_WAIT: outputs go to 0 immediately, and START follows release.
  - With CNT_W=4: 20 consecutive load-use stall cycles give stall_cycles=4'hF.
